// File: rtl/prog_loader.sv
// Serial program loader: assembles big-endian words from framed bytes, writes them
// into RAM port B, verifies an additive checksum and gates the CPU reset.
module prog_loader #(
    parameter logic [9:0]  BASE    = 10'd0,
    parameter logic [23:0] TIMEOUT = 24'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rxd,
    input  logic        rxv,
    output logic [9:0]  ab,
    output logic [15:0] dib,
    output logic        ceb,
    output logic        web,
    output logic        cpu_rst,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LENH, S_LENL, S_DHI, S_DLO, S_CSUM, S_DONE, S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  addr_q, addr_d;
    logic [10:0] cnt_q, cnt_d;
    logic [7:0]  csum_q, csum_d;
    logic [7:0]  len_h_q, len_h_d;
    logic [7:0]  hi_q, hi_d;
    logic [23:0] tmo_q, tmo_d;
    logic [9:0]  ab_q, ab_d;
    logic [15:0] dib_q, dib_d;
    logic        ceb_q, ceb_d;
    logic        cpu_rst_q, cpu_rst_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [15:0] len_w;
    logic [7:0]  csum_sum;
    logic        in_frame;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        csum_d    = csum_q;
        len_h_d   = len_h_q;
        hi_d      = hi_q;
        tmo_d     = tmo_q;
        ab_d      = ab_q;
        dib_d     = dib_q;
        ceb_d     = 1'b0;
        cpu_rst_d = cpu_rst_q;
        done_d    = 1'b0;
        err_d     = err_q;
        len_w     = {len_h_q, rxd};
        csum_sum  = csum_q + rxd;
        in_frame  = state_q inside {S_LENH, S_LENL, S_DHI, S_DLO, S_CSUM};

        case (state_q)
            S_IDLE: begin
                tmo_d = 24'd0;
                if (rxv && rxd == 8'hA5) begin
                    state_d   = S_LENH;
                    cpu_rst_d = 1'b1;
                    err_d     = 1'b0;
                    addr_d    = BASE;
                    csum_d    = 8'd0;
                end
            end
            S_LENH: begin
                if (rxv) begin
                    len_h_d = rxd;
                    state_d = S_LENL;
                end
            end
            S_LENL: begin
                if (rxv) begin
                    if (len_w == 16'd0 || len_w > 16'd1024) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d   = len_w[10:0];
                        state_d = S_DHI;
                    end
                end
            end
            S_DHI: begin
                if (rxv) begin
                    hi_d    = rxd;
                    csum_d  = csum_sum;
                    state_d = S_DLO;
                end
            end
            S_DLO: begin
                if (rxv) begin
                    csum_d  = csum_sum;
                    ceb_d   = 1'b1;
                    ab_d    = addr_q;
                    dib_d   = {hi_q, rxd};
                    addr_d  = addr_q + 10'd1;
                    cnt_d   = cnt_q - 11'd1;
                    state_d = (cnt_q == 11'd1) ? S_CSUM : S_DHI;
                end
            end
            S_CSUM: begin
                if (rxv) begin
                    csum_d = csum_sum;
                    if (csum_sum == 8'd0) begin
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        cpu_rst_d = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                tmo_d   = 24'd0;
            end
            default: state_d = S_IDLE;
        endcase

        // Inter-byte watchdog: only runs while a frame is open.
        if (in_frame) begin
            if (rxv) begin
                tmo_d = 24'd0;
            end else if (tmo_q == TIMEOUT - 24'd1) begin
                tmo_d   = 24'd0;
                state_d = S_ERR;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 24'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= BASE;
            cnt_q     <= 11'd0;
            csum_q    <= 8'd0;
            len_h_q   <= 8'd0;
            hi_q      <= 8'd0;
            tmo_q     <= 24'd0;
            ab_q      <= BASE;
            dib_q     <= 16'd0;
            ceb_q     <= 1'b0;
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            csum_q    <= csum_d;
            len_h_q   <= len_h_d;
            hi_q      <= hi_d;
            tmo_q     <= tmo_d;
            ab_q      <= ab_d;
            dib_q     <= dib_d;
            ceb_q     <= ceb_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign ab      = ab_q;
    assign dib     = dib_q;
    assign ceb     = ceb_q;
    assign web     = ceb_q;
    assign cpu_rst = cpu_rst_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
